lif_neuron_array: RTL and testbench

- Parametrised array of N_CH leaky integrate-and-fire neurons.
- Per-channel input currents; one global runtime-programmable threshold; per-channel refractory period; saturating membrane arithmetic.
- Each channel emits a one-cycle spike pulse. A saturating aggregate spike counter is provided.
- Sits directly under the top-level user wrapper: ui_in drives currents, the 7-seg and bidirectional pins carry spikes and the selected membrane state.

---
 rtl/lif_neuron_array.sv | 95 +++++++++
 tb/tb_lif_neuron_array.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron_array.sv
// rtl/lif_neuron_array.sv - array of leaky integrate-and-fire neurons with shared threshold
// Saturating membranes, per-channel refractory counters and a clamped aggregate spike counter.
module lif_neuron_array #(
  parameter int N_CH        = 2,
  parameter int W           = 8,
  parameter int LEAK_SHIFT  = 1,
  parameter int REFRAC      = 2,
  parameter int THRESH_INIT = 128,
  parameter int SEL_W       = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step_en,
  input  logic [N_CH*W-1:0] current,
  input  logic              thr_we,
  input  logic [W-1:0]      thr_data,
  input  logic [SEL_W-1:0]  sel,
  output logic [N_CH-1:0]   spike_out,
  output logic [W-1:0]      state_out,
  output logic [7:0]        spike_cnt
);

  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  logic [W-1:0]  mem      [N_CH];
  logic [RW-1:0] refr     [N_CH];
  logic [W-1:0]  thr;

  logic [W-1:0]  leaked   [N_CH];
  logic [W:0]    sum      [N_CH];
  logic [W-1:0]  sat      [N_CH];
  logic [W-1:0]  mem_nxt  [N_CH];
  logic [RW-1:0] refr_nxt [N_CH];
  logic [N_CH-1:0] spk_nxt;
  logic [3:0]    pop;
  logic [8:0]    cnt_sum;
  logic [7:0]    cnt_nxt;

  always_comb begin
    spk_nxt = '0;
    pop     = '0;
    for (int k = 0; k < N_CH; k++) begin
      leaked[k]   = mem[k] - (mem[k] >> LEAK_SHIFT);
      sum[k]      = {1'b0, leaked[k]} + {1'b0, current[k*W +: W]};
      sat[k]      = sum[k][W] ? {W{1'b1}} : sum[k][W-1:0];
      mem_nxt[k]  = sat[k];
      refr_nxt[k] = refr[k];
      if (refr[k] != '0) begin
        // Refractory: leak only, input ignored.
        mem_nxt[k]  = leaked[k];
        refr_nxt[k] = refr[k] - 1'b1;
      end else if (sat[k] >= thr) begin
        spk_nxt[k]  = 1'b1;
        mem_nxt[k]  = '0;
        refr_nxt[k] = RW'(REFRAC);
      end
      pop = pop + {3'b000, spk_nxt[k]};
    end
    cnt_sum = {1'b0, spike_cnt} + {5'b00000, pop};
    cnt_nxt = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CH; k++) begin
        mem[k]  <= '0;
        refr[k] <= '0;
      end
      thr       <= W'(THRESH_INIT);
      spike_out <= '0;
      spike_cnt <= '0;
    end else begin
      if (step_en) begin
        for (int k = 0; k < N_CH; k++) begin
          mem[k]  <= mem_nxt[k];
          refr[k] <= refr_nxt[k];
        end
        spike_out <= spk_nxt;
        spike_cnt <= cnt_nxt;
      end else begin
        spike_out <= '0;
      end
      // Compare above used the old threshold; new value applies next edge.
      if (thr_we) thr <= thr_data;
    end
  end

  always_comb begin
    state_out = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (SEL_W'(k) == sel) state_out = mem[k];
    end
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// tb/tb_lif_neuron_array.sv - scoreboard bench for lif_neuron_array
module tb_lif_neuron_array;

  logic        clk;
  logic        rst_n;
  logic        step_en;
  logic [15:0] current;
  logic        thr_we;
  logic [7:0]  thr_data;
  logic [1:0]  sel;
  logic [1:0]  spike_out;
  logic [7:0]  state_out;
  logic [7:0]  spike_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0] spk;
    logic [7:0] st;
    logic [7:0] cnt;
  } exp_t;

  exp_t sbq[$];

  lif_neuron_array #(
    .N_CH(2), .W(8), .LEAK_SHIFT(1), .REFRAC(2), .THRESH_INIT(128), .SEL_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .step_en(step_en), .current(current),
    .thr_we(thr_we), .thr_data(thr_data), .sel(sel),
    .spike_out(spike_out), .state_out(state_out), .spike_cnt(spike_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic apply_reset();
    step_en = 1'b0;
    thr_we  = 1'b0;
    rst_n   = 1'b0;
    sbq.delete();
    #7;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    apply_reset();
    current = {8'd0, 8'd50};
    sel     = 2'd0;
    for (int i = 0; i < 2; i++) begin
      sbq.push_back('{spk: 2'b00, st: (i == 0) ? 8'd50 : 8'd75, cnt: 8'd0});
      step_en = 1'b1;
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      total++;
      if (spike_out !== e.spk || state_out !== e.st || spike_cnt !== e.cnt) begin
        bad++;
        $display("FAIL pre_reset[%0d] got spk=%b st=%0d cnt=%0d want spk=%b st=%0d cnt=%0d",
                 i, spike_out, state_out, spike_cnt, e.spk, e.st, e.cnt);
      end
    end
    step_en = 1'b0;
    #3;
    rst_n = 1'b0;
    sbq.push_back('{spk: 2'b00, st: 8'd0, cnt: 8'd0});
    #1;
    e = sbq.pop_front();
    total++;
    if (spike_out !== e.spk || state_out !== e.st || spike_cnt !== e.cnt) begin
      bad++;
      $display("FAIL async_reset got spk=%b st=%0d cnt=%0d want spk=%b st=%0d cnt=%0d",
               spike_out, state_out, spike_cnt, e.spk, e.st, e.cnt);
    end
    #2;
    rst_n   = 1'b1;
    current = 16'd0;
    sbq.push_back('{spk: 2'b00, st: 8'd0, cnt: 8'd0});
    step_en = 1'b1;
    @(posedge clk);
    #1;
    step_en = 1'b0;
    e = sbq.pop_front();
    total++;
    if (spike_out !== e.spk || state_out !== e.st || spike_cnt !== e.cnt) begin
      bad++;
      $display("FAIL post_reset_step got spk=%b st=%0d cnt=%0d want spk=%b st=%0d cnt=%0d",
               spike_out, state_out, spike_cnt, e.spk, e.st, e.cnt);
    end
  endtask

  task automatic test_convergence();
    exp_t e;
    logic [7:0] es [10] = '{8'd40, 8'd60, 8'd70, 8'd75, 8'd78, 8'd79, 8'd80, 8'd80, 8'd80, 8'd80};
    apply_reset();
    current = {8'd0, 8'd40};
    sel     = 2'd0;
    for (int i = 0; i < 10; i++) begin
      sbq.push_back('{spk: 2'b00, st: es[i], cnt: 8'd0});
      step_en = 1'b1;
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      total++;
      if (spike_out !== e.spk || state_out !== e.st || spike_cnt !== e.cnt) begin
        bad++;
        $display("FAIL converge[%0d] got spk=%b st=%0d cnt=%0d want spk=%b st=%0d cnt=%0d",
                 i, spike_out, state_out, spike_cnt, e.spk, e.st, e.cnt);
      end
    end
    step_en = 1'b0;
  endtask

  task automatic test_refractory();
    exp_t e;
    logic [7:0] es [13] = '{8'd100, 8'd0, 8'd0, 8'd0, 8'd100, 8'd0, 8'd0, 8'd0,
                            8'd100, 8'd0, 8'd0, 8'd0, 8'd100};
    logic       ek [13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                            1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] ec [13] = '{8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2,
                            8'd2, 8'd3, 8'd3, 8'd3, 8'd3};
    apply_reset();
    current = {8'd100, 8'd0};
    sel     = 2'd1;
    for (int i = 0; i < 13; i++) begin
      sbq.push_back('{spk: {ek[i], 1'b0}, st: es[i], cnt: ec[i]});
      step_en = 1'b1;
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      total++;
      if (spike_out !== e.spk || state_out !== e.st || spike_cnt !== e.cnt) begin
        bad++;
        $display("FAIL refrac[%0d] got spk=%b st=%0d cnt=%0d want spk=%b st=%0d cnt=%0d",
                 i, spike_out, state_out, spike_cnt, e.spk, e.st, e.cnt);
      end
    end
    step_en = 1'b0;
    sel = 2'd3;
    sbq.push_back('{spk: 2'b00, st: 8'd0, cnt: 8'd3});
    #1;
    e = sbq.pop_front();
    total++;
    if (state_out !== e.st) begin
      bad++;
      $display("FAIL sel_out_of_range got st=%0d want st=%0d", state_out, e.st);
    end
    sel = 2'd1;
    sbq.push_back('{spk: 2'b00, st: 8'd100, cnt: 8'd3});
    #1;
    e = sbq.pop_front();
    total++;
    if (state_out !== e.st) begin
      bad++;
      $display("FAIL sel_back got st=%0d want st=%0d", state_out, e.st);
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    logic [7:0] es [5] = '{8'd0, 8'd0, 8'd0, 8'd200, 8'd0};
    logic       ek [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] ec [5] = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd2};
    apply_reset();
    current = {8'd0, 8'd200};
    sel     = 2'd0;
    for (int i = 0; i < 5; i++) begin
      sbq.push_back('{spk: {1'b0, ek[i]}, st: es[i], cnt: ec[i]});
      thr_we   = (i == 0);
      thr_data = 8'd255;
      step_en  = 1'b1;
      @(posedge clk);
      #1;
      thr_we = 1'b0;
      e = sbq.pop_front();
      total++;
      if (spike_out !== e.spk || state_out !== e.st || spike_cnt !== e.cnt) begin
        bad++;
        $display("FAIL sat_thr[%0d] got spk=%b st=%0d cnt=%0d want spk=%b st=%0d cnt=%0d",
                 i, spike_out, state_out, spike_cnt, e.spk, e.st, e.cnt);
      end
    end
    step_en = 1'b0;
  endtask

  task automatic test_hold();
    exp_t e;
    logic       en [12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b1, 1'b1, 1'b1};
    logic [7:0] es [13] = '{8'd100, 8'd100, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
                            8'd0, 8'd0, 8'd100, 8'd0};
    logic       ek [13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] ec [13] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1,
                            8'd1, 8'd1, 8'd1, 8'd2};
    apply_reset();
    current = {8'd0, 8'd100};
    sel     = 2'd0;
    for (int i = 0; i < 13; i++) begin
      sbq.push_back('{spk: {1'b0, ek[i]}, st: es[i], cnt: ec[i]});
      step_en = (i < 12) ? en[i] : 1'b1;
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      total++;
      if (spike_out !== e.spk || state_out !== e.st || spike_cnt !== e.cnt) begin
        bad++;
        $display("FAIL hold[%0d] got spk=%b st=%0d cnt=%0d want spk=%b st=%0d cnt=%0d",
                 i, spike_out, state_out, spike_cnt, e.spk, e.st, e.cnt);
      end
    end
    step_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   mcnt;
    logic fire;
    apply_reset();
    current  = {8'd20, 8'd10};
    sel      = 2'd1;
    thr_we   = 1'b1;
    thr_data = 8'd0;
    sbq.push_back('{spk: 2'b00, st: 8'd0, cnt: 8'd0});
    @(posedge clk);
    #1;
    thr_we = 1'b0;
    e = sbq.pop_front();
    total++;
    if (spike_out !== e.spk || state_out !== e.st || spike_cnt !== e.cnt) begin
      bad++;
      $display("FAIL thr_write_idle got spk=%b st=%0d cnt=%0d want spk=%b st=%0d cnt=%0d",
               spike_out, state_out, spike_cnt, e.spk, e.st, e.cnt);
    end
    mcnt = 0;
    for (int i = 0; i < 400; i++) begin
      fire = (i % 3 == 0);
      if (fire) mcnt = (mcnt + 2 > 255) ? 255 : mcnt + 2;
      sbq.push_back('{spk: fire ? 2'b11 : 2'b00, st: 8'd0, cnt: 8'(mcnt)});
      step_en = 1'b1;
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      total++;
      if (spike_out !== e.spk || state_out !== e.st || spike_cnt !== e.cnt) begin
        bad++;
        $display("FAIL cnt_sat[%0d] got spk=%b st=%0d cnt=%0d want spk=%b st=%0d cnt=%0d",
                 i, spike_out, state_out, spike_cnt, e.spk, e.st, e.cnt);
      end
    end
    step_en = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    step_en  = 1'b0;
    current  = '0;
    thr_we   = 1'b0;
    thr_data = '0;
    sel      = '0;
    test_reset();
    test_convergence();
    test_refractory();
    test_saturation();
    test_hold();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
